// File: rtl/decoder_output_serializer.sv
// Serializes one 9-element sigmoid frame into clamped, thresholded beats.
// It also reports the frame's reconstruction Hamming error and keeps a completed-frame count.
module decoder_output_serializer #(
  parameter int                     W         = 20,
  parameter int                     FRAC_BITS = 16,
  parameter logic signed [W-1:0]    THRESH    = 20'sh08000,
  parameter int                     N         = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_bit,
  output logic           out_clamped,
  output logic [3:0]     out_idx,
  output logic           out_last,
  output logic           frame_done,
  output logic [3:0]     err_count,
  output logic [15:0]    frame_cnt
);

  localparam logic signed [W-1:0] ONE      = W'(1 << FRAC_BITS);
  localparam logic [3:0]          LAST_IDX = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic signed [W-1:0]   cap_q [N];
  logic [N-1:0]          x_q;
  logic [3:0]            err_q;
  logic [15:0]           cnt_q;
  logic                  load, last_acc;
  logic [N-1:0]          recon;
  logic signed [W-1:0]   sel;
  logic signed [W-1:0]   sel_clamped;

  // Sign bit catches negatives without risking an unsigned compare.
  function automatic logic signed [W-1:0] clamp_val(input logic signed [W-1:0] v);
    if (v[W-1])
      return '0;
    else if (v > ONE)
      return ONE;
    else
      return v;
  endfunction

  function automatic logic is_clamped(input logic signed [W-1:0] v);
    return v[W-1] || (v > ONE);
  endfunction

  function automatic logic [3:0] popcount(input logic [N-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    last_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            last_acc = 1'b1;
            state_d  = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low through reset and rises one edge after release.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      x_q        <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < N; i++) cap_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      if (load) begin
        x_q <= in_x;
        for (int i = 0; i < N; i++) cap_q[i] <= $signed(in_data[W*i +: W]);
      end
      if (last_acc) begin
        err_q <= popcount(recon ^ x_q);
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Recon bits come straight from the capture registers, independent of beat timing.
  always_comb begin
    recon = '0;
    for (int i = 0; i < N; i++) recon[i] = (clamp_val(cap_q[i]) >= THRESH);
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++)
      if (idx_q == 4'(i)) sel = cap_q[i];
  end

  assign sel_clamped = clamp_val(sel);

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == SEND);
  assign out_data    = out_valid ? sel_clamped : '0;
  assign out_bit     = out_valid && (sel_clamped >= THRESH);
  assign out_clamped = out_valid && is_clamped(sel);
  assign out_idx     = out_valid ? idx_q : '0;
  assign out_last    = out_valid && (idx_q == LAST_IDX);
  assign frame_done  = (state_q == DONE);
  assign err_count   = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: doc/decoder_output_serializer.md
Name: decoder_output_serializer

Overview:
- Downstream consumer of the decoder output layer: takes the 9 sigmoid outputs (20-bit signed fixed point) as one frame, plus the original 9-pixel input vector X.
- Clamps each value to [0, 1.0], thresholds it to a reconstructed pixel bit, and streams the 9 results out one per beat over a valid/ready interface.
- Reports a per-frame reconstruction Hamming error against X, and keeps a frame counter.

Parameters:
- W, 20, data width of each sigmoid output word (signed).
- FRAC_BITS, 16, fractional bits; ONE = 1 << FRAC_BITS = 20'sh10000.
- THRESH, 20'sh08000, pixel-on threshold (0.5); bit = clamped value >= THRESH.
- N, 9, elements per frame (fixed at 9; idx width 4).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  frame available on in_data/in_x.
- in_ready  out  1  block can accept a frame.
- in_data  in  N*W  sigmoid outputs; element i at bits [W*i+W-1 : W*i].
- in_x  in  N  original input pixel bits; bit i pairs with element i.
- out_valid  out  1  out_* beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  W  clamped value of element out_idx.
- out_bit  out  1  thresholded pixel for element out_idx.
- out_clamped  out  1  element out_idx was outside [0, ONE].
- out_idx  out  4  element index 0..8.
- out_last  out  1  high with beat idx 8.
- frame_done  out  1  one-cycle pulse after last beat accepted.
- err_count  out  4  popcount(recon bits XOR in_x) of last completed frame, 0..9.
- frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE. All outputs 0, including in_ready. Capture regs and idx cleared.
  - in_ready goes 1 on the first clk edge after rst_n rises.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register all 9 words and in_x, clear idx, go to SEND; in_ready drops to 0 the same edge.
  - While in SEND or DONE, in_valid is ignored; the frame is held by the upstream source.
- State SEND:
  - out_valid = 1. out_data/out_bit/out_clamped/out_idx derive from capture reg[idx].
  - All out_* stay stable while out_valid & !out_ready.
  - On out_valid & out_ready: if idx == 8, go to DONE; otherwise idx += 1.
  - Beats are never skipped or duplicated.
- State DONE (exactly one cycle):
  - out_valid = 0, frame_done = 1.
  - err_count updates to popcount over the frame and holds until the next DONE.
  - frame_cnt += 1 (mod 2^16).
  - Next state IDLE, with in_ready = 1 the following cycle.
- Latency and throughput:
  - Accept edge is cycle 0; first out_valid is cycle 1.
  - With out_ready held high, beats occupy cycles 1..9, frame_done is cycle 10, and the next accept is possible at cycle 11.
  - Minimum 11 cycles per frame.
- Clamp (signed compare):
  - v < 0 → 0, out_clamped = 1.
  - v > ONE → ONE, out_clamped = 1.
  - Otherwise v, out_clamped = 0.
  - Threshold uses the clamped value; v == THRESH gives bit 1.
- Recon bits: each element's bit is computed from the captured word, and err_count uses all 9 bits regardless of out_ready timing.
- Reset mid-frame: the frame is discarded with no frame_done; frame_cnt and err_count return to 0.

Test Plan:
- Reset: rst_n low for 3 cycles with in_valid = 1 → all outputs 0 and nothing captured; in_ready = 1 one edge after release.
- Nominal frame: all elements 20'sh0C000, in_x = 9'h1FF, out_ready = 1.
  - Beats idx 0..8 on cycles 1..9, out_data = 0x0C000, out_bit = 1, out_last only on idx 8.
  - frame_done on cycle 10, err_count = 0, frame_cnt = 1.
- Clamp/threshold: elements 0..3 = 20'shFFFF0, 20'sh18000, 20'sh08000, 20'sh07FFF.
  - out_data = 0x00000, 0x10000, 0x08000, 0x07FFF.
  - out_clamped = 1, 1, 0, 0.
  - out_bit = 0, 1, 1, 0.
- Error count: elements alternate 0x0C000 / 0x00000 starting at idx 0, in_x = 9'h000 → err_count = 5. A second frame with in_x = 9'h155 → err_count = 0, frame_cnt = 2.
- Backpressure: out_ready low for 3 cycles at idx 4, and in_valid held high throughout SEND.
  - idx-4 beat stays stable, and the sequence 0..8 has no gaps or repeats.
  - No second frame is accepted until after frame_done.
- Reset at idx 3 of SEND: outputs cleared, no frame_done, frame_cnt = 0. A following nominal frame completes correctly with frame_cnt = 1.
